register_bank: RTL and testbench

REGISTER_BANK -- requirements
Module: register_bank

---
 rtl/register_bank_pkg.sv | 6 +
 rtl/register_bank_clear_ctrl.sv | 34 +++
 rtl/register_bank.sv | 53 +++++
 tb/tb_register_bank.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/register_bank_pkg.sv
// register_bank_pkg: shared state type and default geometry for the register bank
package register_bank_pkg;
  typedef enum logic {IDLE, CLEAR} state_t;
  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 5;
endpackage

// File: rtl/register_bank_clear_ctrl.sv
// register_bank_clear_ctrl: IDLE/CLEAR control and the word sweep that zeroes the array
module register_bank_clear_ctrl
  import register_bank_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  output logic             busy_o,
  output logic             clr_we_o,
  output logic [DEPTH-1:0] clr_addr_o
);
  state_t           r_state;
  state_t           w_state_nxt;
  logic [DEPTH-1:0] r_count;
  // state and sweep counter; reset always starts a fresh sweep at word 0
  always_ff @(posedge clk_i)
    if (rst_i) begin
      r_state <= CLEAR;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= (r_state == CLEAR) ? r_count + 1'b1 : '0;
    end
  // clr_i only matters in IDLE; the sweep ends on the edge clearing the last word
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = (r_state == IDLE) ? (clr_i ? CLEAR : IDLE) : (&r_count ? IDLE : CLEAR);
  end
  assign busy_o     = (r_state == CLEAR);
  assign clr_we_o   = busy_o;
  assign clr_addr_o = r_count;
endmodule

// File: rtl/register_bank.sv
// register_bank: word array on a shared tri-state bus with registered reads and a clear sweep
module register_bank
  import register_bank_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cs_ni,
  input  logic             oe_i,
  input  logic             we_i,
  input  logic             clr_i,
  input  logic [DEPTH-1:0] address_i,
  inout  wire  [WIDTH-1:0] data_io,
  output logic             busy_o,
  output logic             rvalid_o
);
  logic [WIDTH-1:0] r_mem [2**DEPTH];
  logic [WIDTH-1:0] r_rdata;
  logic             r_rvalid;
  logic             w_clr_we;
  logic [DEPTH-1:0] w_clr_addr;
  logic             w_acc;
  logic             w_wr;
  logic             w_rd;
  register_bank_clear_ctrl #(.DEPTH(DEPTH)) u_clear_ctrl (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (clr_i),
    .busy_o     (busy_o),
    .clr_we_o   (w_clr_we),
    .clr_addr_o (w_clr_addr)
  );
  assign w_acc = !rst_i && !busy_o && !cs_ni && !clr_i;
  assign w_wr  = w_acc && we_i && !oe_i;
  assign w_rd  = w_acc && oe_i && !we_i;
  // the sweep owns the array while busy; otherwise accepted writes land here
  always_ff @(posedge clk_i)
    if (w_clr_we) r_mem[w_clr_addr] <= '0;
    else if (w_wr) r_mem[address_i] <= data_io;
  // read register: one-cycle latency, valid only for the cycle after capture
  always_ff @(posedge clk_i)
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_rd;
      if (w_rd) r_rdata <= r_mem[address_i];
    end
  assign data_io  = (r_rvalid && !cs_ni && oe_i) ? r_rdata : 'z;
  assign rvalid_o = r_rvalid;
endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: randomized and directed checks of register_bank against a behavioural model
module tb_register_bank;
  logic       clk = 1'b0;
  logic       rst, cs_n, oe, we, clr;
  logic [4:0] addr;
  logic [7:0] wdata;
  tri1  [7:0] data_io;
  logic       busy, rvalid;
  logic       tb_en;
  int         checks = 0;
  int         failures = 0;
  bit         m_on = 1'b0;
  bit         m_busy = 1'b0;
  bit         m_rvalid = 1'b0;
  int         m_sweep = 0;
  logic [7:0] m_rdata = 8'h00;
  logic [7:0] m_mem [32];

  always #5 clk = ~clk;

  assign tb_en   = we && !(m_rvalid && !cs_n && oe);
  assign data_io = tb_en ? wdata : 'z;

  register_bank #(.WIDTH(8), .DEPTH(5)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .cs_ni     (cs_n),
    .oe_i      (oe),
    .we_i      (we),
    .clr_i     (clr),
    .address_i (addr),
    .data_io   (data_io),
    .busy_o    (busy),
    .rvalid_o  (rvalid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] e);
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, e, $time);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_busy = 1'b1;
      m_sweep = 0;
      m_rvalid = 1'b0;
      m_rdata = 8'h00;
    end else if (m_busy) begin
      m_mem[m_sweep] = 8'h00;
      m_rvalid = 1'b0;
      m_sweep++;
      if (m_sweep == 32) begin
        m_busy = 1'b0;
        m_sweep = 0;
      end
    end else begin
      m_rvalid = 1'b0;
      if (clr) m_busy = 1'b1;
      else if (!cs_n && we && !oe) m_mem[addr] = wdata;
      else if (!cs_n && oe && !we) begin
        m_rvalid = 1'b1;
        m_rdata = m_mem[addr];
      end
    end
  endtask

  task automatic cyc(input logic r, input logic c, input logic o, input logic w, input logic cl,
                     input logic [4:0] a, input logic [7:0] d);
    rst = r; cs_n = c; oe = o; we = w; clr = cl; addr = a; wdata = d;
    @(posedge clk);
    model_step();
    m_on = 1'b1;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, a, d);
  endtask

  task automatic read_expect(input logic [4:0] a, input logic [7:0] e, input string name);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, a, 8'h00);
    chk({name, "_rvalid"}, rvalid, 1);
    chk(name, data_io, e);
  endtask

  always @(negedge clk)
    if (m_on) begin
      chk("busy_o", busy, m_busy);
      chk("rvalid_o", rvalid, m_rvalid);
      chk("data_io", data_io, (m_rvalid && !cs_n && oe) ? m_rdata : (tb_en ? wdata : 8'hFF));
    end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [4:0] ra;
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    chk("reset_busy", busy, 1);
    chk("reset_rvalid", rvalid, 0);
    n = 0;
    while (busy && n < 100) begin
      idle();
      n++;
    end
    chk("reset_sweep_len", n, 32);
    for (int a = 0; a < 32; a++) read_expect(5'(a), 8'h00, "init_zero");
    wr(5'd3, 8'hA5);
    read_expect(5'd3, 8'hA5, "wr_rd_3");
    cs_n = 1'b1;
    #1;
    chk("bus_z_cs", data_io, 8'hFF);
    wr(5'd31, 8'h3C);
    wr(5'd0, 8'hC3);
    read_expect(5'd31, 8'h3C, "pre_clr_31");
    read_expect(5'd0, 8'hC3, "pre_clr_0");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 8'h00);
    chk("clr_no_capture", rvalid, 0);
    n = 0;
    while (busy && n < 100) begin
      wr(5'(n), 8'h55);
      n++;
    end
    chk("clr_sweep_len", n, 32);
    read_expect(5'd0, 8'h00, "clr_0");
    read_expect(5'd31, 8'h00, "clr_31");
    read_expect(5'd3, 8'h00, "clr_3");
    idle();
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 8'hFF);
    chk("illegal_rvalid", rvalid, 0);
    idle();
    chk("illegal_rvalid_idle", rvalid, 0);
    read_expect(5'd7, 8'h00, "illegal_addr7");
    for (int i = 0; i < 600; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      cyc($urandom_range(0, 149) == 0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), $urandom_range(0, 59) == 0, ra, 8'($urandom_range(0, 254)));
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    repeat (10) idle();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    chk("midrst_busy", busy, 1);
    n = 0;
    while (busy && n < 100) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, n % 4 == 0, 5'd0, 8'h00);
      n++;
    end
    chk("midrst_sweep_len", n, 32);
    read_expect(5'd3, 8'h00, "post_midrst_3");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
